// File: rtl/pdh_cmd_pkg.sv
// Shared command codes, field positions and payload types for the PDH DAC path.
package pdh_cmd_pkg;

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned DATA_W = 26;
  localparam int unsigned CB_W   = 32;
  localparam int unsigned LANE_W = 16;

  // AXI-GPIO command word field positions
  localparam int unsigned CH_LSB     = 14;
  localparam int unsigned CH_W       = 5;
  localparam int unsigned RST_BIT    = 31;
  localparam int unsigned STROBE_BIT = 30;
  localparam int unsigned CMD_LSB    = 26;

  // Callback word bit positions (mirrored by cb_t below)
  localparam int unsigned CB_CMD_LSB = 28;
  localparam int unsigned CB_STB_BIT = 27;
  localparam int unsigned CB_ERR_BIT = 26;

  typedef enum logic [CMD_W-1:0] {
    CMD_IDLE      = 4'd0,
    CMD_SET_LED   = 4'd1,
    CMD_SET_DAC   = 4'd2,
    CMD_RAMP_STEP = 4'd3,
    CMD_RAMP_DIV  = 4'd4,
    CMD_RAMP_CTRL = 4'd5
  } cmd_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Callback word returned to the PS: {cmd, strobe echo, err, data}
  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic              strobe;
    logic              err;
    logic [DATA_W-1:0] data;
  } cb_t;

  // Builds a full AXI-GPIO command word from its fields
  function automatic logic [CB_W-1:0] axi_word(input logic              rst_bit,
                                               input logic              stb_bit,
                                               input logic [CMD_W-1:0]  cmd,
                                               input logic [DATA_W-1:0] data);
    logic [CB_W-1:0] w;
    w                     = '0;
    w[RST_BIT]            = rst_bit;
    w[STROBE_BIT]         = stb_bit;
    w[CMD_LSB +: CMD_W]   = cmd;
    w[DATA_W-1:0]         = data;
    return w;
  endfunction

  // Builds a callback word from its fields using the callback bit positions
  function automatic logic [CB_W-1:0] cb_word(input logic [CMD_W-1:0]  cmd,
                                              input logic              stb,
                                              input logic              err,
                                              input logic [DATA_W-1:0] data);
    logic [CB_W-1:0] w;
    w                        = '0;
    w[CB_CMD_LSB +: CMD_W]   = cmd;
    w[CB_STB_BIT]            = stb;
    w[CB_ERR_BIT]            = err;
    w[DATA_W-1:0]            = data;
    return w;
  endfunction

endpackage

// File: rtl/pdh_dac_ctrl_if.sv
// PS command / callback and packed DAC stream bundle.
interface pdh_dac_ctrl_if #(
  parameter int unsigned N_CH = 2
);
  import pdh_cmd_pkg::*;

  logic [CMD_W-1:0]       cmd_i;
  logic [DATA_W-1:0]      data_i;
  logic                   strobe_i;
  logic [CB_W-1:0]        cb_o;
  logic [LANE_W*N_CH-1:0] dac_tdata_o;
  logic                   dac_tvalid_o;

  modport master (
    output cmd_i, data_i, strobe_i,
    input  cb_o, dac_tdata_o, dac_tvalid_o
  );

  modport slave (
    input  cmd_i, data_i, strobe_i,
    output cb_o, dac_tdata_o, dac_tvalid_o
  );

endinterface

// File: rtl/pdh_ramp_ch.sv
// One DAC channel: static setpoint plus clamped triangle sweep.
module pdh_ramp_ch #(
  parameter int unsigned DAC_W = 14,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_i,
  input  logic             step_we_i,
  input  logic             div_we_i,
  input  logic             ctrl_we_i,
  input  logic [DAC_W-1:0] val_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [1:0]       ctrl_i,
  output logic [DAC_W-1:0] value_o,
  output logic             changed_c
);
  import pdh_cmd_pkg::*;

  localparam int unsigned       SUM_W   = DAC_W + 1;
  localparam logic [SUM_W-1:0]  MAX_EXT = {1'b0, {DAC_W{1'b1}}};

  logic [DAC_W-1:0] value_q, value_d;
  logic [DAC_W-1:0] step_q, step_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  dir_t             dir_q, dir_d;
  logic             tick_c;
  logic [SUM_W-1:0] sum_c;

  // Next-state: divider tick, clamped up/down step, then command overrides
  always_comb begin
    value_d = value_q;
    step_d  = step_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    dir_d   = dir_q;
    tick_c  = en_q && (cnt_q >= div_q);
    sum_c   = {1'b0, value_q} + {1'b0, step_q};

    if (en_q) begin
      cnt_d = tick_c ? '0 : cnt_q + DIV_W'(1);
    end

    if (tick_c) begin
      if (dir_q == DIR_UP) begin
        if (sum_c > MAX_EXT) begin
          value_d = '1;
          dir_d   = DIR_DOWN;
        end else begin
          value_d = sum_c[DAC_W-1:0];
        end
      end else begin
        if (step_q > value_q) begin
          value_d = '0;
          dir_d   = DIR_UP;
        end else begin
          value_d = value_q - step_q;
        end
      end
    end

    // A setpoint load replaces the tick result and leaves direction alone
    if (set_i) begin
      value_d = val_i;
      dir_d   = dir_q;
    end
    if (step_we_i) begin
      step_d = val_i;
    end
    if (div_we_i) begin
      div_d = div_i;
    end
    // Ramp control drops any coincident tick and restarts the divider
    if (ctrl_we_i) begin
      en_d    = ctrl_i[0];
      dir_d   = dir_t'(ctrl_i[1]);
      cnt_d   = '0;
      value_d = value_q;
    end

    changed_c = (value_d != value_q);
  end

  // Channel state register
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      step_q  <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      dir_q   <= DIR_UP;
    end else begin
      value_q <= value_d;
      step_q  <= step_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      dir_q   <= dir_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/pdh_dac_ctrl.sv
// PS command decode, per-channel ramp instances and packed DAC stream output.
module pdh_dac_ctrl #(
  parameter int unsigned DAC_W = 14,
  parameter int unsigned N_CH  = 2,
  parameter int unsigned DIV_W = 16
) (
  input logic           clk,
  input logic           rst,
  pdh_dac_ctrl_if.slave bus
);
  import pdh_cmd_pkg::*;

  localparam int unsigned      CHK_W  = CH_W + 1;
  localparam logic [CHK_W-1:0] N_CH_L = CHK_W'(N_CH);

  logic                   strobe_q, strobe_d;
  logic                   edge_c;
  logic                   pend_q, pend_d;
  logic [CMD_W-1:0]       cmd_q, cmd_d;
  logic [DATA_W-1:0]      data_q, data_d;
  cb_t                    cb_q, cb_d;
  logic                   tvalid_q, tvalid_d;

  logic [CH_W-1:0]        ch_c;
  logic                   ch_ok_c;
  logic                   chan_cmd_c;
  logic                   valid_cmd_c;
  logic                   err_c;
  logic [N_CH-1:0]        set_we_c;
  logic [N_CH-1:0]        step_we_c;
  logic [N_CH-1:0]        div_we_c;
  logic [N_CH-1:0]        ctrl_we_c;
  logic [N_CH-1:0]        changed_c;
  logic [DAC_W-1:0]       value_w [N_CH];
  logic [LANE_W*N_CH-1:0] tdata_c;

  // Strobe rising-edge detect and one-stage command capture
  always_comb begin
    strobe_d = bus.strobe_i;
    edge_c   = bus.strobe_i & ~strobe_q;
    pend_d   = edge_c;
    cmd_d    = cmd_q;
    data_d   = data_q;
    if (edge_c) begin
      cmd_d  = bus.cmd_i;
      data_d = bus.data_i;
    end
  end

  // Decode the captured command into per-channel write enables
  always_comb begin
    ch_c        = data_q[CH_LSB +: CH_W];
    ch_ok_c     = CHK_W'(ch_c) < N_CH_L;
    chan_cmd_c  = 1'b0;
    valid_cmd_c = 1'b0;
    set_we_c    = '0;
    step_we_c   = '0;
    div_we_c    = '0;
    ctrl_we_c   = '0;

    case (cmd_q)
      CMD_IDLE: begin
        valid_cmd_c = 1'b1;
      end
      CMD_SET_DAC, CMD_RAMP_STEP, CMD_RAMP_DIV, CMD_RAMP_CTRL: begin
        valid_cmd_c = 1'b1;
        chan_cmd_c  = 1'b1;
      end
      default: begin
        valid_cmd_c = 1'b0;
      end
    endcase

    err_c = !valid_cmd_c || (chan_cmd_c && !ch_ok_c);

    if (pend_q && !err_c) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (ch_c == CH_W'(k)) begin
          set_we_c[k]  = (cmd_q == CMD_SET_DAC);
          step_we_c[k] = (cmd_q == CMD_RAMP_STEP);
          div_we_c[k]  = (cmd_q == CMD_RAMP_DIV);
          ctrl_we_c[k] = (cmd_q == CMD_RAMP_CTRL);
        end
      end
    end
  end

  // Callback word and the single shared stream-valid pulse
  always_comb begin
    cb_d        = cb_q;
    cb_d.strobe = bus.strobe_i;
    if (pend_q) begin
      cb_d.cmd  = cmd_q;
      cb_d.err  = err_c;
      cb_d.data = data_q;
    end
    tvalid_d = |changed_c;
  end

  // Top-level register stage; strobe_q resets high so a held strobe cannot fire
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_q <= 1'b1;
      pend_q   <= 1'b0;
      cmd_q    <= '0;
      data_q   <= '0;
      cb_q     <= '0;
      tvalid_q <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
      pend_q   <= pend_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      cb_q     <= cb_d;
      tvalid_q <= tvalid_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pdh_ramp_ch #(
      .DAC_W (DAC_W),
      .DIV_W (DIV_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .set_i     (set_we_c[g]),
      .step_we_i (step_we_c[g]),
      .div_we_i  (div_we_c[g]),
      .ctrl_we_i (ctrl_we_c[g]),
      .val_i     (data_q[DAC_W-1:0]),
      .div_i     (data_q[DIV_W-1:0]),
      .ctrl_i    (data_q[1:0]),
      .value_o   (value_w[g]),
      .changed_c (changed_c[g])
    );
  end

  // Pack channel values into 16-bit lanes, unused lane bits zero
  always_comb begin
    tdata_c = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      tdata_c[LANE_W*k +: DAC_W] = value_w[k];
    end
  end

  assign bus.cb_o         = cb_q;
  assign bus.dac_tdata_o  = tdata_c;
  assign bus.dac_tvalid_o = tvalid_q;

endmodule

// File: tb/tb_pdh_dac_ctrl.sv
// Directed scoreboard bench for pdh_dac_ctrl with four channels.
module tb_pdh_dac_ctrl;
  import pdh_cmd_pkg::*;

  localparam int unsigned DAC_W = 14;
  localparam int unsigned N_CH  = 4;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned TW    = 16 * N_CH;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;
  int tv_cnt = 0;
  int tv0;

  logic [TW-1:0]    exp_q [$];
  logic [DAC_W-1:0] exp_val [N_CH];
  logic [DAC_W-1:0] ramp_seq [9] = '{14'h1000, 14'h2000, 14'h3000, 14'h3FFF,
                                     14'h2FFF, 14'h1FFF, 14'h0FFF, 14'h0000,
                                     14'h1000};

  pdh_dac_ctrl_if #(.N_CH(N_CH)) bus ();

  pdh_dac_ctrl #(
    .DAC_W (DAC_W),
    .N_CH  (N_CH),
    .DIV_W (DIV_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] pack_exp();
    logic [TW-1:0] w;
    w = '0;
    for (int k = 0; k < N_CH; k++) w[16*k +: DAC_W] = exp_val[k];
    return w;
  endfunction

  task automatic push_exp();
    exp_q.push_back(pack_exp());
  endtask

  // Every stream pulse must match the oldest expected word
  always @(negedge clk) begin
    if (bus.dac_tvalid_o === 1'b1) begin
      tv_cnt++;
      check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("sb_tdata", 64'(bus.dac_tdata_o), 64'(exp_q.pop_front()));
    end
  end

  // One strobe pulse; returns #1 after the execution edge k+1
  task automatic do_cmd(input logic [3:0] cmd, input logic [25:0] data,
                        input logic exp_tv, input logic exp_err);
    bus.cmd_i    = cmd;
    bus.data_i   = data;
    bus.strobe_i = 1'b1;
    @(posedge clk); #1;
    check("no_early_tvalid", 64'(bus.dac_tvalid_o), 64'd0);
    bus.strobe_i = 1'b0;
    bus.cmd_i    = 4'hF;
    bus.data_i   = 26'($urandom);
    @(posedge clk); #1;
    check("cmd_tvalid", 64'(bus.dac_tvalid_o), 64'(exp_tv));
    check("cmd_tdata", 64'(bus.dac_tdata_o), 64'(pack_exp()));
    check("cmd_cb", 64'(bus.cb_o), 64'({cmd, 1'b0, exp_err, data}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_i    = '0;
    bus.data_i   = '0;
    bus.strobe_i = 1'b0;
    for (int k = 0; k < N_CH; k++) exp_val[k] = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tdata", 64'(bus.dac_tdata_o), 64'd0);
    check("rst_tvalid", 64'(bus.dac_tvalid_o), 64'd0);
    check("rst_cb", 64'(bus.cb_o), 64'd0);

    // Strobe held high across reset release must not execute
    bus.cmd_i    = CMD_SET_DAC;
    bus.data_i   = 26'h0000777;
    bus.strobe_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("held_rst_tdata", 64'(bus.dac_tdata_o), 64'd0);
    check("held_rst_cb", 64'(bus.cb_o), 64'h0800_0000);
    bus.strobe_i = 1'b0;
    @(posedge clk); #1;

    // Static setpoints on several channels
    exp_val[0] = 14'h0123; push_exp();
    do_cmd(CMD_SET_DAC, 26'h0000123, 1'b1, 1'b0);
    check("set_lo32_a", 64'(bus.dac_tdata_o[31:0]), 64'h0000_0123);
    exp_val[1] = 14'h1ABC; push_exp();
    do_cmd(CMD_SET_DAC, 26'h0005ABC, 1'b1, 1'b0);
    check("set_lo32_b", 64'(bus.dac_tdata_o[31:0]), 64'h1ABC_0123);
    exp_val[0] = 14'h0005; push_exp();
    do_cmd(CMD_SET_DAC, 26'h0000005, 1'b1, 1'b0);
    check("set_lo32_c", 64'(bus.dac_tdata_o[31:0]), 64'h1ABC_0005);
    exp_val[3] = 14'h2000; push_exp();
    do_cmd(CMD_SET_DAC, 26'h000E000, 1'b1, 1'b0);
    check("set_ch3", 64'(bus.dac_tdata_o[61:48]), 64'h2000);

    // Unchanged value, bad channel, bad code, idle
    do_cmd(CMD_SET_DAC, 26'h0000005, 1'b0, 1'b0);
    do_cmd(CMD_SET_DAC, 26'h0015234, 1'b0, 1'b1);
    check("bad_ch_err", 64'(bus.cb_o[26]), 64'd1);
    do_cmd(4'h7, 26'h0001234, 1'b0, 1'b1);
    do_cmd(CMD_SET_LED, 26'h0000001, 1'b0, 1'b1);
    do_cmd(CMD_IDLE, 26'h2AAAAAA, 1'b0, 1'b0);

    // Strobe held for 20 cycles: one execution only
    exp_val[0] = 14'h0042; push_exp();
    tv0 = tv_cnt;
    bus.cmd_i    = CMD_SET_DAC;
    bus.data_i   = 26'h0000042;
    bus.strobe_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("held_cb", 64'(bus.cb_o), 64'h2800_0042);
    check("held_tvalid", 64'(bus.dac_tvalid_o), 64'd1);
    repeat (18) @(posedge clk);
    #1;
    bus.strobe_i = 1'b0;
    @(posedge clk); #1;
    check("held_cb_drop", 64'(bus.cb_o), 64'h2000_0042);
    check("held_pulses", 64'(tv_cnt - tv0), 64'd1);

    // Triangle sweep on ch0 from 0, step 0x1000, period 4
    exp_val[0] = 14'h0000; push_exp();
    do_cmd(CMD_SET_DAC, 26'h0000000, 1'b1, 1'b0);
    do_cmd(CMD_RAMP_STEP, 26'h0001000, 1'b0, 1'b0);
    do_cmd(CMD_RAMP_DIV, 26'h0000003, 1'b0, 1'b0);
    do_cmd(CMD_RAMP_CTRL, 26'h0000001, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      exp_val[0] = ramp_seq[i]; push_exp();
      repeat (4) @(posedge clk);
      #1;
      check("ramp_tvalid", 64'(bus.dac_tvalid_o), 64'd1);
      check("ramp_tdata", 64'(bus.dac_tdata_o), 64'(pack_exp()));
    end

    // SET landing on a tick edge wins, ramp resumes upward from it
    repeat (2) @(posedge clk);
    #1;
    exp_val[0] = 14'h0100; push_exp();
    do_cmd(CMD_SET_DAC, 26'h0000100, 1'b1, 1'b0);
    exp_val[0] = 14'h1100; push_exp();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.dac_tvalid_o === 1'b1) break;
    end
    check("resume_tvalid", 64'(bus.dac_tvalid_o), 64'd1);
    check("resume_tdata", 64'(bus.dac_tdata_o), 64'(pack_exp()));

    // Reset mid-ramp clears everything and the ramp stays stopped
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_tdata", 64'(bus.dac_tdata_o), 64'd0);
    check("midrst_tvalid", 64'(bus.dac_tvalid_o), 64'd0);
    check("midrst_cb", 64'(bus.cb_o), 64'd0);
    rst = 1'b0;
    for (int k = 0; k < N_CH; k++) exp_val[k] = '0;
    tv0 = tv_cnt;
    repeat (12) @(posedge clk);
    #1;
    check("stopped_tdata", 64'(bus.dac_tdata_o), 64'd0);
    check("stopped_pulses", 64'(tv_cnt - tv0), 64'd0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
